// File: rtl/instr_encoder_if.sv
// Request/response bundle between an instruction-field producer and instr_encoder.
// The producer side is the master; the encoder is the slave.
interface instr_encoder_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic             in_is_li32;
    logic [3:0]       in_group;
    logic [3:0]       in_ra;
    logic [3:0]       in_rb;
    logic [3:0]       in_rc;
    logic [3:0]       in_opcode;
    logic [15:0]      in_imm;
    logic [31:0]      in_imm32;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic             out_bad;
    logic             out_last;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid, in_is_li32, in_group, in_ra, in_rb, in_rc,
               in_opcode, in_imm, in_imm32, out_ready,
        input  in_ready, out_valid, out_instr, out_bad, out_last, out_count
    );

    modport slave (
        input  in_valid, in_is_li32, in_group, in_ra, in_rb, in_rc,
               in_opcode, in_imm, in_imm32, out_ready,
        output in_ready, out_valid, out_instr, out_bad, out_last, out_count
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs decoded Frost32 instruction fields into 32-bit words, expanding the
// LI32 macro into addi + cpyhi, behind a registered valid/ready output stage.
module instr_encoder #(
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic rst,
    instr_encoder_if.slave bus
);
    typedef enum logic {IDLE, LI_HI} state_t;

    state_t      state;
    state_t      state_next;
    logic        load_ok;
    logic        accept;
    logic        load_en;
    logic        latch_hi;
    logic [31:0] word_d;
    logic        bad_d;
    logic        last_d;
    logic [3:0]  hi_ra;
    logic [15:0] hi_imm;

    // The output register may be reloaded whenever it is empty or being drained.
    assign load_ok      = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = load_ok && (state == IDLE);
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && bus.in_is_li32 && (bus.in_imm32[31:16] != 16'h0000))
                         state_next = LI_HI;
            LI_HI:   if (load_ok)
                         state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Selects the word to load: the pending cpyhi takes priority, so an LI32 pair stays contiguous.
    always_comb begin
        word_d   = 32'h0000_0000;
        bad_d    = 1'b0;
        last_d   = 1'b0;
        load_en  = 1'b0;
        latch_hi = 1'b0;
        if (state == LI_HI) begin
            load_en = load_ok;
            word_d  = {4'h1, hi_ra, 4'h0, 4'hD, hi_imm};
            last_d  = 1'b1;
        end else if (accept) begin
            load_en = 1'b1;
            if (bus.in_is_li32) begin
                word_d   = {4'h1, bus.in_ra, 4'h0, 4'h0, bus.in_imm32[15:0]};
                last_d   = (bus.in_imm32[31:16] == 16'h0000);
                latch_hi = (bus.in_imm32[31:16] != 16'h0000);
            end else begin
                last_d = 1'b1;
                if (bus.in_group == 4'h1) begin
                    word_d = {4'h1, bus.in_ra, bus.in_rb, bus.in_opcode, bus.in_imm};
                end else begin
                    word_d = {bus.in_group, bus.in_ra, bus.in_rb, bus.in_rc, 12'h000, bus.in_opcode};
                end
                bad_d = (bus.in_group > 4'h3)
                     || ((bus.in_group == 4'h0) && (bus.in_opcode >= 4'd12))
                     || ((bus.in_group == 4'h2) && (bus.in_opcode >= 4'd4))
                     || ((bus.in_group == 4'h3) && (bus.in_opcode >= 4'd8));
            end
        end
    end

    // Word fields only change on a load, so a stalled word stays put.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_instr <= 32'h0000_0000;
            bus.out_bad   <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_count <= '0;
            hi_ra         <= 4'h0;
            hi_imm        <= 16'h0000;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                bus.out_count <= bus.out_count + 1'b1;
            end
            if (load_en) begin
                bus.out_valid <= 1'b1;
                bus.out_instr <= word_d;
                bus.out_bad   <= bad_d;
                bus.out_last  <= last_d;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            if (latch_hi) begin
                hi_ra  <= bus.in_ra;
                hi_imm <= bus.in_imm32[31:16];
            end
        end
    end
endmodule
